// File: rtl/sm83_irq_ctl.sv
// sm83_irq_ctl: N-channel interrupt controller (IE/IF/IME, edge detect, priority, dispatch FSM).
// Optional macro SM83_IRQ_EARLY_LATCH_EN latches the winning channel at take instead of at resolve.
module sm83_irq_ctl #(
  parameter int NUM_IRQS   = 8,
  parameter int ADR_WIDTH  = 16,
  parameter int VEC_BASE   = 'h0040,
  parameter int VEC_STRIDE = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_IRQS-1:0]  irq,
  input  logic [NUM_IRQS-1:0]  din,
  input  logic                 ie_we,
  input  logic                 if_we,
  output logic [NUM_IRQS-1:0]  ie,
  output logic [NUM_IRQS-1:0]  iflag,
  input  logic                 ei,
  input  logic                 di,
  input  logic                 reti,
  input  logic                 instr_end,
  output logic                 ime,
  output logic                 wake,
  output logic                 int_req,
  input  logic                 take,
  input  logic                 resolve,
  input  logic                 done,
  output logic [ADR_WIDTH-1:0] vector,
  output logic                 vec_valid,
  output logic [NUM_IRQS-1:0]  iack,
  output logic [1:0]           fsm_state
);

  localparam int IDX_W = (NUM_IRQS > 1) ? $clog2(NUM_IRQS) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, HELD = 2'd2} state_t;

  state_t                state, state_nxt;
  logic [NUM_IRQS-1:0]   irq_prev, edge_det, pend, if_nxt, res_clr;
  logic [NUM_IRQS-1:0]   enc_onehot, res_onehot;
  logic [IDX_W-1:0]      enc_idx, res_idx;
  logic                  enc_found, res_found;
  logic                  ei_pend, do_take, do_resolve;
  logic [ADR_WIDTH-1:0]  vec_calc;

  // Handshake: take/resolve/done are one-cycle strobes from control; take is
  // honoured only in IDLE, resolve only in ARMED, done only in HELD.
  assign edge_det   = irq & ~irq_prev;
  assign pend       = ie & iflag;
  assign wake       = |pend;
  assign do_take    = take && (state == IDLE);
  assign do_resolve = resolve && (state == ARMED);

  // Lowest pending index wins.
  always_comb begin
    enc_found  = 1'b0;
    enc_idx    = '0;
    enc_onehot = '0;
    for (int i = 0; i < NUM_IRQS; i++) begin
      if (pend[i] && !enc_found) begin
        enc_found     = 1'b1;
        enc_idx       = IDX_W'(i);
        enc_onehot[i] = 1'b1;
      end
    end
  end

`ifdef SM83_IRQ_EARLY_LATCH_EN
  logic                lat_found;
  logic [IDX_W-1:0]    lat_idx;
  logic [NUM_IRQS-1:0] lat_onehot;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_found  <= 1'b0;
      lat_idx    <= '0;
      lat_onehot <= '0;
    end else if (do_take) begin
      lat_found  <= enc_found;
      lat_idx    <= enc_idx;
      lat_onehot <= enc_onehot;
    end
  end

  assign res_found  = lat_found;
  assign res_idx    = lat_idx;
  assign res_onehot = lat_onehot;
`else
  assign res_found  = enc_found;
  assign res_idx    = enc_idx;
  assign res_onehot = enc_onehot;
`endif

  assign vec_calc = ADR_WIDTH'(VEC_BASE + int'(res_idx) * VEC_STRIDE);
  assign res_clr  = (do_resolve && res_found) ? res_onehot : '0;
  // A fresh edge outranks the resolve clear, which outranks a software write.
  assign if_nxt   = edge_det | (~res_clr & (if_we ? din : iflag));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ie       <= '0;
      iflag    <= '0;
      irq_prev <= '1;
      ime      <= 1'b0;
      ei_pend  <= 1'b0;
      iack     <= '0;
      vector   <= '0;
    end else begin
      irq_prev <= irq;
      iflag    <= if_nxt;
      if (ie_we) ie <= din;
      iack <= '0;
      if (do_resolve) begin
        if (res_found) begin
          vector <= vec_calc;
          iack   <= res_onehot;
        end else begin
          vector <= '0;
        end
      end
      // EI arms a pending enable that lands on the following instruction boundary.
      if (di || do_take) begin
        ime     <= 1'b0;
        ei_pend <= 1'b0;
      end else if (reti) begin
        ime <= 1'b1;
      end else if (ei) begin
        ei_pend <= 1'b1;
      end else if (instr_end && ei_pend) begin
        ime     <= 1'b1;
        ei_pend <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (take)    state_nxt = ARMED;
      ARMED:   if (resolve) state_nxt = HELD;
      HELD:    if (done)    state_nxt = IDLE;
      default:              state_nxt = IDLE;
    endcase
  end

  always_comb begin
    int_req   = ime && wake && (state == IDLE);
    vec_valid = (state == HELD);
    fsm_state = state;
  end

endmodule

// File: tb/tb_sm83_irq_ctl.sv
// Bench for sm83_irq_ctl: directed scenarios plus randomized traffic checked every cycle
// against a register-level behavioural model; a 16-channel instance covers the wide case.
module tb_sm83_irq_ctl;
  localparam int N = 8;
  localparam int P_IDLE = 0, P_ARMED = 1, P_HELD = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic check_en = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  logic [N-1:0] irq = '1, din = '0;
  logic ie_we = 0, if_we = 0, ei = 0, di = 0, reti = 0, instr_end = 0;
  logic take = 0, resolve = 0, done = 0;
  logic [N-1:0] ie, iflag, iack;
  logic ime, wake, int_req, vec_valid;
  logic [15:0] vector;
  logic [1:0] fsm_state;

  logic [15:0] x_din = '0;
  logic x_ie_we = 0, x_if_we = 0, x_reti = 0, x_take = 0, x_resolve = 0;
  logic [15:0] x_ie, x_iflag, x_iack, x_vector;
  logic x_ime, x_wake, x_int_req, x_vec_valid;
  logic [1:0] x_fsm;

  always #5 clk = ~clk;

  sm83_irq_ctl #(.NUM_IRQS(N)) dut (
    .clk(clk), .reset(rst), .irq(irq), .din(din), .ie_we(ie_we), .if_we(if_we),
    .ie(ie), .iflag(iflag), .ei(ei), .di(di), .reti(reti), .instr_end(instr_end),
    .ime(ime), .wake(wake), .int_req(int_req), .take(take), .resolve(resolve),
    .done(done), .vector(vector), .vec_valid(vec_valid), .iack(iack), .fsm_state(fsm_state)
  );

  sm83_irq_ctl #(.NUM_IRQS(16)) dut16 (
    .clk(clk), .reset(rst), .irq(16'hFFFF), .din(x_din), .ie_we(x_ie_we), .if_we(x_if_we),
    .ie(x_ie), .iflag(x_iflag), .ei(1'b0), .di(1'b0), .reti(x_reti), .instr_end(1'b0),
    .ime(x_ime), .wake(x_wake), .int_req(x_int_req), .take(x_take), .resolve(x_resolve),
    .done(1'b0), .vector(x_vector), .vec_valid(x_vec_valid), .iack(x_iack), .fsm_state(x_fsm)
  );

  // Behavioural model of the 8-channel instance.
  logic [N-1:0] m_ie, m_if, m_prev, m_iack, m_lat;
  logic         m_ime, m_pend;
  int           m_phase;
  logic [15:0]  m_vec;

  function automatic logic [N-1:0] lowest(input logic [N-1:0] s);
    logic [N-1:0] neg;
    neg = ~s + 1'b1;
    return s & neg;
  endfunction

  always @(posedge clk or posedge rst) begin
    logic [N-1:0] edges, win, clr, base;
    logic tk;
    if (rst) begin
      m_ie = '0; m_if = '0; m_prev = '1; m_iack = '0; m_lat = '0;
      m_ime = 0; m_pend = 0; m_phase = P_IDLE; m_vec = '0;
    end else begin
      tk    = take && (m_phase == P_IDLE);
      edges = irq & ~m_prev;
      m_prev = irq;
      clr    = '0;
      m_iack = '0;
      if (m_phase == P_ARMED && resolve) begin
`ifdef SM83_IRQ_EARLY_LATCH_EN
        win = m_lat;
`else
        win = lowest(m_ie & m_if);
`endif
        if (win != 0) begin
          m_vec  = 16'('h40 + 8 * $clog2(win));
          m_iack = win;
          clr    = win;
        end else begin
          m_vec = '0;
        end
      end
      if (tk) m_lat = lowest(m_ie & m_if);
      base = if_we ? din : m_if;
      m_if = edges | (base & ~clr);
      if (ie_we) m_ie = din;
      if (di || tk) begin m_ime = 0; m_pend = 0; end
      else if (reti) m_ime = 1;
      else if (ei) m_pend = 1;
      else if (instr_end && m_pend) begin m_ime = 1; m_pend = 0; end
      case (m_phase)
        P_IDLE:  if (take)    m_phase = P_ARMED;
        P_ARMED: if (resolve) m_phase = P_HELD;
        default: if (done)    m_phase = P_IDLE;
      endcase
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en && !rst) begin
      chk("ie", ie, m_ie);
      chk("iflag", iflag, m_if);
      chk("ime", ime, m_ime);
      chk("wake", wake, (m_ie & m_if) != 0);
      chk("int_req", int_req, m_ime && ((m_ie & m_if) != 0) && m_phase == P_IDLE);
      chk("vec_valid", vec_valid, m_phase == P_HELD);
      chk("vector", vector, m_vec);
      chk("iack", iack, m_iack);
    end
  end

  task automatic step();
    @(negedge clk);
    {ie_we, if_we, ei, di, reti, instr_end, take, resolve, done} = '0;
    {x_ie_we, x_if_we, x_reti, x_take, x_resolve} = '0;
  endtask

  initial begin
    #1 rst = 1'b1;
    step(); step();
    rst = 1'b0;
    check_en = 1'b1;
    chk("rst_ie", ie, 8'h00);
    chk("rst_iflag", iflag, 8'h00);
    chk("rst_ime", ime, 1'b0);
    chk("rst_vec_valid", vec_valid, 1'b0);
    chk("rst_vector", vector, 16'h0000);

    // irq high through reset must not look like an edge
    step(); step();
    chk("no_spurious_edge", iflag, 8'h00);
    irq = 8'h00; step();
    irq = 8'h04; step();
    chk("edge_ch2", iflag, 8'h04);

    // basic dispatch
    din = 8'h05; ie_we = 1; if_we = 1; step();
    reti = 1; step();
    chk("int_req_on", int_req, 1'b1);
    take = 1; step();
    chk("int_req_armed", int_req, 1'b0);
    chk("state_armed", fsm_state, 2'd1);
    resolve = 1; step();
    chk("vec_ch0", vector, 16'h0040);
    chk("iack_ch0", iack, 8'h01);
    chk("iflag_after_res", iflag, 8'h04);
    chk("vec_valid_held", vec_valid, 1'b1);
    step();
    chk("iack_one_cycle", iack, 8'h00);
    done = 1; reti = 1; step();
    chk("vec_valid_idle", vec_valid, 1'b0);
    chk("int_req_again", int_req, 1'b1);

    // delayed EI
    di = 1; din = 8'h01; ie_we = 1; if_we = 1; step();
    ei = 1; instr_end = 1; step();
    chk("ei_same_boundary", ime, 1'b0);
    instr_end = 1; step();
    chk("ei_next_boundary", ime, 1'b1);
    chk("ei_int_req", int_req, 1'b1);
    di = 1; step();
    ei = 1; instr_end = 1; step();
    di = 1; step();
    instr_end = 1; step();
    chk("di_cancels_ei", ime, 1'b0);

    // IE cleared between take and resolve
    reti = 1; step();
    take = 1; step();
    din = 8'h00; ie_we = 1; step();
    resolve = 1; step();
`ifdef SM83_IRQ_EARLY_LATCH_EN
    chk("late_ie_vector", vector, 16'h0040);
    chk("late_ie_iack", iack, 8'h01);
    chk("late_ie_iflag", iflag, 8'h00);
`else
    chk("cancel_vector", vector, 16'h0000);
    chk("cancel_iack", iack, 8'h00);
    chk("cancel_iflag", iflag, 8'h01);
`endif
    done = 1; step();

    // edge on the bit being resolved keeps it set
    din = 8'h01; ie_we = 1; if_we = 1; irq = 8'h00; step();
    reti = 1; step();
    take = 1; step();
    resolve = 1; irq = 8'h01; step();
    chk("edge_res_iack", iack, 8'h01);
    chk("edge_res_iflag", iflag, 8'h01);
    done = 1; step();
    din = 8'h00; if_we = 1; irq = 8'h09; step();
    chk("edge_beats_write", iflag, 8'h08);

    // 16-channel instance and reset while HELD
    x_din = 16'h8000; x_ie_we = 1; x_if_we = 1; step();
    x_reti = 1; step();
    x_take = 1; step();
    x_resolve = 1; step();
    chk("x16_vector", x_vector, 16'h00B8);
    chk("x16_iack", x_iack, 16'h8000);
    chk("x16_vec_valid", x_vec_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("x16_rst_state", x_fsm, 2'd0);
    chk("x16_rst_vec_valid", x_vec_valid, 1'b0);
    chk("x16_rst_ime", x_ime, 1'b0);
    chk("x16_rst_vector", x_vector, 16'h0000);
    chk("x16_rst_iack", x_iack, 16'h0000);
    step();
    #2 rst = 1'b0;
    step();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      irq       = irq ^ N'($urandom & $urandom & $urandom);
      din       = N'($urandom);
      ie_we     = ($urandom_range(0, 7) == 0);
      if_we     = ($urandom_range(0, 7) == 0);
      ei        = ($urandom_range(0, 7) == 0);
      di        = ($urandom_range(0, 15) == 0);
      reti      = ($urandom_range(0, 11) == 0);
      instr_end = ($urandom_range(0, 2) == 0);
      take      = (m_phase == P_IDLE) && ($urandom_range(0, 2) == 0);
      resolve   = (m_phase == P_ARMED) && ($urandom_range(0, 1) == 0);
      done      = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      if ($urandom_range(0, 299) == 0) begin
        #2 rst = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
      end
    end
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/sm83_irq_ctl.md
Name: sm83_irq_ctl

Overview:
- Parametrised interrupt controller for the sm83 core. Replaces the fixed 8-bit irq/iack pair with an N-channel unit.
- Holds the IE (enable), IF (flag) and IME (master enable) registers, including the delayed-EI rule.
- Detects rising edges on the request lines and resolves priority (lowest index wins).
- Supplies the dispatch vector and a one-hot acknowledge to sm83_control during the interrupt-dispatch M-cycles.

Parameters:
NUM_IRQS, 8, number of request channels (1..16)
ADR_WIDTH, 16, width of the vector output
VEC_BASE, 'h0040, vector of channel 0
VEC_STRIDE, 8, address distance between consecutive channel vectors

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-high reset
irq  in  NUM_IRQS  request lines; a rising edge sets the matching IF bit
din  in  NUM_IRQS  write data for IE/IF
ie_we  in  1  load IE from din
if_we  in  1  load IF from din
ie  out  NUM_IRQS  IE register
iflag  out  NUM_IRQS  IF register
ei  in  1  EI instruction strobe
di  in  1  DI instruction strobe
reti  in  1  RETI strobe; sets IME immediately
instr_end  in  1  one-cycle strobe at each instruction boundary
ime  out  1  master enable
wake  out  1  |(ie & iflag), independent of IME; used for HALT exit
int_req  out  1  ime & wake & state==IDLE; dispatch request to control
take  in  1  control starts dispatch
resolve  in  1  control samples the vector
done  in  1  dispatch finished
vector  out  ADR_WIDTH  dispatch target
vec_valid  out  1  vector is held stable
iack  out  NUM_IRQS  one-hot, pulses for one cycle on resolve

Behaviour:
- Reset values (asynchronous): ie=0, iflag=0, ime=0, ei_pend=0, irq_prev=all ones (no spurious edge after reset), state=IDLE, iack=0, vector=0, vec_valid=0.
- Edge detect: edge = irq & ~irq_prev; irq_prev <= irq every cycle.
- Per-bit IF update priority, highest first:
  1. edge sets the bit.
  2. resolve clears the resolved bit.
  3. if_we loads the bit from din.
  A new edge on the bit being resolved in the same cycle keeps it set.
- IE: updated by ie_we only. The new value is visible next cycle.
- IME, priority highest first:
  1. di: ime<=0 and ei_pend<=0.
  2. take: ime<=0 and ei_pend<=0.
  3. reti: ime<=1.
  4. ei: ei_pend<=1. ime is unchanged this cycle.
  5. instr_end with ei_pend=1: ime<=1, ei_pend<=0.
  ei and instr_end in the same cycle do not enable IME; enabling takes effect at the following instr_end.
- FSM states: IDLE, ARMED, HELD.
  - IDLE --take--> ARMED. take outside IDLE is ignored.
  - ARMED --resolve--> HELD.
  - HELD --done--> IDLE. done in IDLE/ARMED is ignored.
- On resolve:
  - p = lowest index with ie[p]&iflag[p].
  - vector <= VEC_BASE + p*VEC_STRIDE, truncated to ADR_WIDTH.
  - iack <= onehot(p) for exactly one cycle; iflag[p] is cleared.
  - If no bit qualifies: vector <= 0, iack stays 0, no IF bit cleared (the cancelled-dispatch case).
- vec_valid=1 only in HELD. vector holds its value until the next resolve.
- reset mid-dispatch: returns to IDLE immediately with all outputs at their reset values.

Optional Feature:
SM83_IRQ_EARLY_LATCH_EN
- Defined: p is latched at take (registered in ARMED). resolve then uses the latched p, so IE/IF writes between take and resolve cannot cancel or redirect the dispatch. The latched IF bit is still cleared on resolve.
- Undefined: p is computed at resolve, as specified above. This is the default and is sm83-accurate.

Test Plan:
- After reset: irq held high produces no IF set. Drop irq then raise it → iflag[2]=1 one cycle after the edge on ch2.
- ie='h05, iflag='h05, ime=1 → int_req=1. take, then resolve → vector='h0040, iack='h01, iflag='h04. done → IDLE, int_req=1 again.
- ei, instr_end, instr_end with ie=iflag='h01 → ime=0 after the first instr_end, ime=1 and int_req=1 after the second. di between the two keeps ime=0.
- take, then ie_we din=0, then resolve (macro off) → vector='h0000, iack=0, iflag unchanged. Macro on → vector='h0040, iack='h01.
- Edge on ch0 in the same cycle as resolve of ch0 → iflag[0] stays 1. if_we din='h00 together with an edge on ch3 → iflag='h08.
- NUM_IRQS=16, ie=iflag='h8000 → vector='h00B8. reset asserted while in HELD → state IDLE, vec_valid=0, ime=0 immediately.
